// File: rtl/wave_capture_buffer_if.sv
// Sample-stream, renderer-read and status bundle for wave_capture_buffer.
// master = sample source / renderer side, slave = the capture buffer.
interface wave_capture_buffer_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
);
    logic              sample_en;
    logic [DATA_W-1:0] sample_in;
    logic              rearm;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              capturing;
    logic              frame_ready;
    logic              trig_auto;

    modport master (
        output sample_en, sample_in, rearm, rd_addr,
        input  rd_data, capturing, frame_ready, trig_auto
    );

    modport slave (
        input  sample_en, sample_in, rearm, rd_addr,
        output rd_data, capturing, frame_ready, trig_auto
    );
endinterface

// File: rtl/wave_capture_buffer.sv
// Single-shot triggered capture of one screen width of samples, frozen until rearm.
// Optional AUTO_TRIG_EN: forces a trigger after TIMEOUT samples spent waiting in ARMED.
module wave_capture_buffer #(
    parameter int DATA_W     = 10,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = 10,
    parameter int TRIG_LEVEL = 512,
    parameter int TIMEOUT    = 2048
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    wave_capture_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] TRIG_L = DATA_W'(TRIG_LEVEL);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

    if (((2 ** ADDR_W) < DEPTH) || (TIMEOUT < 1)) begin : g_param_check
        $error("wave_capture_buffer: ADDR_W too small for DEPTH or TIMEOUT < 1");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] prev_sample_q, prev_sample_d;
    logic              prev_valid_q, prev_valid_d;
    logic              capturing_q, capturing_d;
    logic              frame_ready_q, frame_ready_d;
    logic              trig_auto_q, trig_auto_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              level_trig_s;
    logic              fire_s;
    logic              fire_auto_s;
    logic              rd_in_range_s;

`ifdef AUTO_TRIG_EN
    localparam int             CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_L = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_inc_s;
`endif

    assign level_trig_s  = prev_valid_q && (prev_sample_q < TRIG_L) && (bus.sample_in >= TRIG_L);
    assign rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_A);

    // Next-state, write-port and status decode.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        trig_auto_d   = trig_auto_q;
        mem_we_s      = 1'b0;
        mem_addr_s    = wr_ptr_q;
        mem_wdata_s   = bus.sample_in;
        fire_s        = 1'b0;
        fire_auto_s   = 1'b0;
`ifdef AUTO_TRIG_EN
        tmo_cnt_d     = tmo_cnt_q;
        tmo_cnt_inc_s = tmo_cnt_q + CNT_W'(1);
`endif
        case (state_q)
            ST_ARMED: begin
                if (bus.sample_en) begin
                    prev_sample_d = bus.sample_in;
                    prev_valid_d  = 1'b1;
                    if (level_trig_s) begin
                        fire_s = 1'b1;
                    end else begin
`ifdef AUTO_TRIG_EN
                        tmo_cnt_d = tmo_cnt_inc_s;
                        if (tmo_cnt_inc_s == TMO_L) begin
                            fire_s      = 1'b1;
                            fire_auto_s = 1'b1;
                        end else begin
                            fire_s = 1'b0;
                        end
`else
                        fire_s = 1'b0;
`endif
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (bus.sample_en) begin
                    mem_we_s = 1'b1;
                    if (wr_ptr_q == LAST_A) begin
                        state_d = ST_HOLD;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_HOLD: begin
                // A sample arriving with rearm is deliberately dropped.
                if (bus.rearm) begin
                    state_d      = ST_ARMED;
                    prev_valid_d = 1'b0;
                    wr_ptr_d     = {ADDR_W{1'b0}};
`ifdef AUTO_TRIG_EN
                    tmo_cnt_d    = {CNT_W{1'b0}};
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d      = ST_ARMED;
                prev_valid_d = 1'b0;
                wr_ptr_d     = {ADDR_W{1'b0}};
            end
        endcase

        if (fire_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = {ADDR_W{1'b0}};
            wr_ptr_d    = ADDR_W'(1);
            state_d     = ST_CAPTURE;
            trig_auto_d = fire_auto_s;
`ifdef AUTO_TRIG_EN
            tmo_cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
            mem_addr_s = mem_addr_s;
        end

        capturing_d   = (state_d == ST_CAPTURE);
        frame_ready_d = (state_d == ST_HOLD);
    end

    // Read-first registered read; out-of-range columns read as zero.
    always_comb begin
        rd_data_d = {DATA_W{1'b0}};
        if (rd_in_range_s) begin
            rd_data_d = mem_q[bus.rd_addr];
        end else begin
            rd_data_d = {DATA_W{1'b0}};
        end
    end

    // Control and output registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_ARMED;
            wr_ptr_q      <= {ADDR_W{1'b0}};
            prev_sample_q <= {DATA_W{1'b0}};
            prev_valid_q  <= 1'b0;
            capturing_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            trig_auto_q   <= 1'b0;
            rd_data_q     <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            capturing_q   <= capturing_d;
            frame_ready_q <= frame_ready_d;
            trig_auto_q   <= trig_auto_d;
            rd_data_q     <= rd_data_d;
        end
    end

`ifdef AUTO_TRIG_EN
    // Samples spent waiting in ARMED.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt_q <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // Frame storage; contents survive reset.
    always_ff @(posedge CLOCK) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.capturing   = capturing_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.trig_auto   = trig_auto_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Scoreboard bench for wave_capture_buffer: read expectations are queued when an
// address is driven and compared when the registered read data appears.
module tb_wave_capture_buffer;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 640;

    logic CLOCK = 1'b0;
    logic RESET_N;

    wave_capture_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wave_capture_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .TRIG_LEVEL(512), .TIMEOUT(2048)
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        bus.sample_en = 1'b1;
        bus.sample_in = DATA_W'(v);
        step();
        bus.sample_en = 1'b0;
        for (int g = 1; g < gap; g++) step();
    endtask

    task automatic rd_push(input int addr, input int exp);
        bus.rd_addr = ADDR_W'(addr);
        exp_q.push_back(DATA_W'(exp));
    endtask

    task automatic rd_pop(input string tag);
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        check_eq(tag, 32'(bus.rd_data), 32'(e));
    endtask

    task automatic rd_read(input string tag, input int addr, input int exp);
        rd_push(addr, exp);
        step();
        rd_pop(tag);
    endtask

    task automatic pulse_rearm();
        bus.rearm = 1'b1;
        step();
        bus.rearm = 1'b0;
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.sample_in = '0;
        bus.rearm     = 1'b0;
        bus.rd_addr   = '0;
        RESET_N       = 1'b0;
        step();
        step();
        check_eq("rst_capturing", 32'(bus.capturing), 32'd0);
        check_eq("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check_eq("rst_trig_auto", 32'(bus.trig_auto), 32'd0);
        RESET_N = 1'b1;
        step();

        // Frame 1: ramp 0..639 wrapping, one sample every 4 clocks.
        for (int i = 0; i < 1152; i++) begin
            send(i % 640, (i == 1151) ? 1 : 4);
            if (i == 511) check_eq("f1_no_trig_511", 32'(bus.capturing), 32'd0);
            if (i == 512) check_eq("f1_trig_512", 32'(bus.capturing), 32'd1);
            if (i == 1150) check_eq("f1_fr_before_last", 32'(bus.frame_ready), 32'd0);
            if (i == 1151) begin
                check_eq("f1_fr_after_last", 32'(bus.frame_ready), 32'd1);
                check_eq("f1_cap_after_last", 32'(bus.capturing), 32'd0);
            end
        end
        check_eq("f1_trig_auto", 32'(bus.trig_auto), 32'd0);
        rd_read("f1_a0", 0, 512);
        rd_read("f1_a127", 127, 639);
        rd_read("f1_a128", 128, 0);
        rd_read("f1_a639", 639, 511);
        rd_read("f1_a700", 700, 0);

        // Frozen frame ignores further samples.
        for (int i = 0; i < 1000; i++) send(int'($urandom_range(0, 1023)), 1);
        check_eq("hold_fr", 32'(bus.frame_ready), 32'd1);
        rd_read("hold_a0", 0, 512);

        // Rearm together with a sample: sample dropped.
        bus.rearm     = 1'b1;
        bus.sample_en = 1'b1;
        bus.sample_in = DATA_W'(600);
        step();
        bus.rearm     = 1'b0;
        bus.sample_en = 1'b0;
        check_eq("rearm_fr", 32'(bus.frame_ready), 32'd0);

        // Frame 2: 639->0 wrap must not trigger; post-trigger values step by 2.
        for (int i = 600; i < 1152; i++) begin
            send(i % 640, 1);
            if (i == 640) check_eq("f2_no_trig_wrap", 32'(bus.capturing), 32'd0);
        end
        check_eq("f2_no_trig_511", 32'(bus.capturing), 32'd0);
        send(512, 1);
        check_eq("f2_trig", 32'(bus.capturing), 32'd1);
        for (int k = 1; k < 640; k++) begin
            if (k == 5) begin
                rd_push(5, 517);
                send((512 + 2 * k) % 1024, 1);
                rd_pop("f2_read_first_old");
                rd_read("f2_read_first_new", 5, 522);
            end else begin
                send((512 + 2 * k) % 1024, 1);
            end
        end
        check_eq("f2_fr", 32'(bus.frame_ready), 32'd1);
        rd_read("f2_a0", 0, 512);
        rd_read("f2_a1", 1, 514);
        rd_read("f2_a639", 639, 766);
        check_eq("f2_trig_auto", 32'(bus.trig_auto), 32'd0);

        // Frame 3: abandoned by reset after 300 captured samples.
        pulse_rearm();
        for (int i = 0; i < 512; i++) send(i, 1);
        send(512, 1);
        for (int k = 1; k < 300; k++) send(k, 1);
        check_eq("f3_capturing", 32'(bus.capturing), 32'd1);
        bus.rd_addr = ADDR_W'(0);
        step();
        #3;
        RESET_N = 1'b0;
        #1;
        check_eq("mid_rst_capturing", 32'(bus.capturing), 32'd0);
        check_eq("mid_rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        check_eq("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
        check_eq("mid_rst_trig_auto", 32'(bus.trig_auto), 32'd0);
        step();
        step();
        RESET_N = 1'b1;
        check_eq("post_rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        rd_read("partial_a1", 1, 1);
        rd_read("partial_a299", 299, 299);
        rd_read("partial_a300", 300, 88);

        // Frame 4: ramp starting at 512 after reset; first sample must not trigger.
        send(512, 1);
        check_eq("f4_first_no_trig", 32'(bus.capturing), 32'd0);
        for (int i = 513; i < 1152; i++) send(i % 640, 1);
        check_eq("f4_no_trig_511", 32'(bus.capturing), 32'd0);
        send(512, 1);
        check_eq("f4_trig", 32'(bus.capturing), 32'd1);
        for (int k = 1; k < 640; k++) begin
            bus.rearm = (k == 100) ? 1'b1 : 1'b0;
            send((512 + k) % 640, 1);
        end
        bus.rearm = 1'b0;
        check_eq("f4_fr", 32'(bus.frame_ready), 32'd1);
        rd_read("f4_a0", 0, 512);
        rd_read("f4_a1", 1, 513);
        rd_read("f4_a299", 299, 171);
        rd_read("f4_a639", 639, 511);

        // Constant input: only the timeout can start a frame.
        pulse_rearm();
        for (int n = 1; n <= 5000; n++) begin
            send(100, 1);
`ifdef AUTO_TRIG_EN
            if (n == 2047) check_eq("tmo_before", 32'(bus.capturing), 32'd0);
            if (n == 2048) begin
                check_eq("tmo_capturing", 32'(bus.capturing), 32'd1);
                check_eq("tmo_trig_auto", 32'(bus.trig_auto), 32'd1);
            end
`endif
        end
`ifdef AUTO_TRIG_EN
        check_eq("const_fr", 32'(bus.frame_ready), 32'd1);
        check_eq("const_trig_auto", 32'(bus.trig_auto), 32'd1);
        rd_read("const_a0", 0, 100);
        rd_read("const_a639", 639, 100);
`else
        check_eq("const_fr", 32'(bus.frame_ready), 32'd0);
        check_eq("const_capturing", 32'(bus.capturing), 32'd0);
        check_eq("const_trig_auto", 32'(bus.trig_auto), 32'd0);
        rd_read("const_a0", 0, 512);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
Triggered single-shot capture stage directly downstream of the slow-clock sample source (test ramp or mic sampler). Watches the sample stream for a rising crossing of a trigger level, stores one full screen width (640) of consecutive samples, then freezes the frame for the display renderer. The renderer reads by column address and re-arms the buffer when finished.

Parameters:
DATA_W, 10, sample width in bits
DEPTH, 640, samples per frame (one per screen column)
ADDR_W, 10, address width, must satisfy 2^ADDR_W >= DEPTH
TRIG_LEVEL, 512, rising-edge trigger threshold (unsigned)
TIMEOUT, 2048, samples in ARMED before auto-trigger (AUTO_TRIG_EN only)

Ports:
CLOCK  in  1  system clock, all logic on posedge
RESET_N  in  1  asynchronous active-low reset
sample_en  in  1  one-CLOCK strobe per new sample
sample_in  in  DATA_W  sample value, valid when sample_en=1
rearm  in  1  pulse from renderer: release frozen frame, re-arm
rd_addr  in  ADDR_W  display column to read
rd_data  out  DATA_W  stored sample at rd_addr, registered
capturing  out  1  high while in CAPTURE
frame_ready  out  1  high while in HOLD (frame complete, frozen)
trig_auto  out  1  last frame started by timeout (0 without AUTO_TRIG_EN)

Behaviour:
- Reset (RESET_N low, async): state=ARMED, wr_ptr=0, prev_sample=0, prev_valid=0, rd_data=0, capturing=0, frame_ready=0, trig_auto=0, timeout counter=0. Memory contents not cleared.
- Sample qualifier: every cycle with sample_en=1 is one sample; held-high sample_en counts once per cycle.
- ARMED: on each sample, prev_sample<=sample_in, prev_valid<=1. Trigger when prev_valid=1 and prev_sample<TRIG_LEVEL and sample_in>=TRIG_LEVEL. Triggering sample written to address 0, wr_ptr<=1, state<=CAPTURE. First sample after reset/rearm never triggers.
- CAPTURE: each sample written to wr_ptr, wr_ptr increments. Write to DEPTH-1 moves state to HOLD same edge; frame_ready=1 from next cycle. capturing=1 exactly while in CAPTURE.
- HOLD: samples ignored, memory frozen. rearm=1 -> state ARMED, frame_ready=0 next cycle, prev_valid=0, wr_ptr=0, timeout counter=0.
- rearm in ARMED or CAPTURE ignored. rearm and sample_en same cycle in HOLD: rearm taken, sample discarded.
- Read port: rd_data registered, 1-cycle latency, available in all states. Read-first: same-address read/write in one cycle returns old data. rd_addr>=DEPTH returns 0.
- Width: comparisons unsigned, DATA_W bits; wr_ptr never exceeds DEPTH-1.
- Reset mid-CAPTURE: abandon frame, return to ARMED as above; partially written memory stays but frame_ready stays 0.

Optional Feature:
AUTO_TRIG_EN defined: in ARMED, counter increments per sample; sample that brings count to TIMEOUT with no level trigger forces trigger (written to address 0, CAPTURE as normal) and sets trig_auto=1; a level trigger sets trig_auto=0. trig_auto holds until next trigger or reset. Not defined: no counter, ARMED waits indefinitely, trig_auto tied 0.

Test Plan:
- Reset: assert RESET_N=0 mid-clock -> immediately capturing=0, frame_ready=0, rd_data=0, trig_auto=0.
- Ramp 0..639 wrapping, sample_en every 4 CLOCKs, TRIG_LEVEL=512 -> trigger on 511->512; frame_ready rises one cycle after 640th stored sample; rd_addr 0->512, 127->639, 128->0, 639->511, each one cycle after address applied.
- Frame held: 1000 more samples in HOLD -> rd_addr 0 still 512; rearm pulse -> frame_ready=0 next cycle, 639->0 wrap causes no trigger, next frame again starts at 512.
- Constant sample_in=100 for 5000 samples -> without AUTO_TRIG_EN frame_ready stays 0; with AUTO_TRIG_EN (TIMEOUT=2048) capturing=1 after 2048th sample, rd_addr 0->100, trig_auto=1.
- Reset after 300 captured samples, then ramp starting at 512 -> no trigger on first sample (prev_valid=0); frame starts at next 511->512 crossing.
- rd_addr=700 -> rd_data=0; rd_addr=5 read on the cycle sample 5 is written in CAPTURE -> previous contents returned, new value on following read.
